// File: rtl/systolic_pkg.sv
// Shared types and size helpers for the systolic MAC array and its result drain.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } drain_state_t;

  function automatic int npe_of(input int dim);
    return dim * dim;
  endfunction

  // Width of a pointer over all PEs; at least one bit so a 1x1 array still builds.
  function automatic int idx_bits_of(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

// File: rtl/result_bank.sv
// Per-PE snapshot registers with captured flags and a read mux on the drain pointer.
module result_bank #(
  parameter int NPE      = 16,
  parameter int W        = 21,
  parameter int IDX_BITS = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NPE-1:0]      i_we,
  input  logic [NPE*W-1:0]    i_wdata,
  input  logic                i_clear,
  input  logic [IDX_BITS-1:0] i_ptr,
  output logic [NPE-1:0]      o_captured,
  output logic [W-1:0]        o_rdata
);

  logic [NPE-1:0][W-1:0] bank_w;

  for (genvar k = 0; k < NPE; k++) begin : g_ent
    logic [W-1:0] word_q;
    logic         cap_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        word_q <= '0;
        cap_q  <= 1'b0;
      end else begin
        if (i_we[k]) word_q <= i_wdata[k*W +: W];
        if (i_clear)     cap_q <= 1'b0;
        else if (i_we[k]) cap_q <= 1'b1;
      end
    end

    assign bank_w[k]     = word_q;
    assign o_captured[k] = cap_q;
  end

  assign o_rdata = bank_w[i_ptr];

endmodule

// File: rtl/systolic_result_drain.sv
// Collects PE accumulator snapshots as finish flags arrive, then streams them row-major.
// Optional RESULT_DRAIN_INDEX_EN adds o_index carrying the drain pointer.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int  DIMENSION  = 4,
  parameter int  REG_C_BITS = 21,
  localparam int NPE        = npe_of(DIMENSION),
  localparam int IDX_BITS   = idx_bits_of(DIMENSION)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [NPE-1:0]            i_finish,
  input  logic [NPE*REG_C_BITS-1:0] i_c,
  output logic [REG_C_BITS-1:0]     o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
`ifdef RESULT_DRAIN_INDEX_EN
  output logic [IDX_BITS-1:0]       o_index,
`endif
  output logic                      o_busy,
  output logic                      o_overflow,
  input  logic                      i_clear_overflow
);

  drain_state_t          state_q, state_d;
  logic [NPE-1:0]        captured, fin_v, cap_we;
  logic [IDX_BITS-1:0]   ptr_q, ptr_d;
  logic                  ovf_q, ovf_d, ovf_set;
  logic [REG_C_BITS-1:0] rdata;
  logic                  all_cap, xfer, last, clr_cap;

  assign fin_v   = i_valid ? i_finish : '0;
  assign cap_we  = (state_q != DRAIN) ? (fin_v & ~captured) : '0;
  assign all_cap = &(captured | cap_we);
  assign xfer    = (state_q == DRAIN) && i_ready;
  assign last    = (ptr_q == IDX_BITS'(NPE - 1));
  assign clr_cap = xfer && last;

  result_bank #(
    .NPE      (NPE),
    .W        (REG_C_BITS),
    .IDX_BITS (IDX_BITS)
  ) u_bank (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_we       (cap_we),
    .i_wdata    (i_c),
    .i_clear    (clr_cap),
    .i_ptr      (ptr_q),
    .o_captured (captured),
    .o_rdata    (rdata)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|cap_we) state_d = all_cap ? DRAIN : COLLECT;
      COLLECT: if (all_cap) state_d = DRAIN;
      DRAIN:   if (clr_cap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state_q == DRAIN);
    o_busy  = (state_q != IDLE);
    o_data  = o_valid ? rdata : '0;
  end

  // Drops and repeats are both reported; in DRAIN the capture path is closed so any finish is lost.
  assign ovf_set = ((state_q == DRAIN) && (|fin_v)) ||
                   ((state_q == COLLECT) && (|(fin_v & captured)));

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = last ? '0 : ptr_q + 1'b1;
    ovf_d = ovf_q;
    if (ovf_set)               ovf_d = 1'b1;
    else if (i_clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;

`ifdef RESULT_DRAIN_INDEX_EN
  assign o_index = ptr_q;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: directed tables, corner sequences, random vs model.
module tb_systolic_result_drain;
  localparam int N = 16;
  localparam int W = 21;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_valid, i_ready, i_clear_overflow;
  logic [N-1:0]   i_finish;
  logic [N*W-1:0] i_c;
  logic [W-1:0]   o_data;
  logic           o_valid, o_busy, o_overflow;
`ifdef RESULT_DRAIN_INDEX_EN
  logic [3:0]     o_index;
`endif

  systolic_result_drain #(.DIMENSION(4), .REG_C_BITS(W)) dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_valid          (i_valid),
    .i_finish         (i_finish),
    .i_c              (i_c),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
`ifdef RESULT_DRAIN_INDEX_EN
    .o_index          (o_index),
`endif
    .o_busy           (o_busy),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction-level model: which PEs hold a value, and the queue of words still to deliver.
  bit          got[N];
  logic [W-1:0] vals[N];
  logic [W-1:0] q[$];
  bit          m_ovf;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin got[k] = 0; vals[k] = '0; end
    q.delete();
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit v, input logic [N-1:0] fin, input bit rdy, input bit clr);
    bit set = 0;
    bit all;
    if (q.size() != 0) begin
      if (v && fin != 0) set = 1;
      if (rdy) begin
        void'(q.pop_front());
        if (q.size() == 0) for (int k = 0; k < N; k++) got[k] = 0;
      end
    end else if (v) begin
      for (int k = 0; k < N; k++)
        if (fin[k]) begin
          if (got[k]) set = 1;
          else begin got[k] = 1; vals[k] = i_c[k*W +: W]; end
        end
      all = 1;
      for (int k = 0; k < N; k++) if (!got[k]) all = 0;
      if (all) for (int k = 0; k < N; k++) q.push_back(vals[k]);
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  function automatic bit model_busy();
    bit b = (q.size() != 0);
    for (int k = 0; k < N; k++) if (got[k]) b = 1;
    return b;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, q.size() != 0});
    check({tag, "_data"}, {11'd0, o_data}, (q.size() != 0) ? {11'd0, q[0]} : 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, {31'd0, model_busy()});
    check({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, m_ovf});
`ifdef RESULT_DRAIN_INDEX_EN
    check({tag, "_index"}, {28'd0, o_index}, (q.size() != 0) ? 32'(N - q.size()) : 32'd0);
`endif
  endtask

  task automatic step(input bit v, input logic [N-1:0] fin, input bit rdy, input bit clr, input string tag);
    i_valid = v; i_finish = fin; i_ready = rdy; i_clear_overflow = clr;
    @(posedge clk);
    model_edge(v, fin, rdy, clr);
    #1;
    compare_model(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic mid_reset(input string tag);
    i_valid = 0; i_finish = '0; i_ready = 0; i_clear_overflow = 0;
    #2 rst_n = 0;
    #1;
    check({tag, "_rst_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_rst_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_rst_ovf"}, {31'd0, o_overflow}, 32'd0);
    check({tag, "_rst_data"}, {11'd0, o_data}, 32'd0);
    model_reset();
    #3 rst_n = 1;
  endtask

  function automatic logic [N-1:0] diag(input int d);
    logic [N-1:0] r = '0;
    for (int k = 0; k < N; k++) if ((k / 4) + (k % 4) == d) r[k] = 1'b1;
    return r;
  endfunction

  task automatic set_c_plus1();
    for (int k = 0; k < N; k++) i_c[k*W +: W] = W'(k + 1);
  endtask

  typedef struct {
    bit           v;
    logic [N-1:0] fin;
    bit           rdy;
    bit           clr;
    int           cofs;
    bit           ev;
    bit           eb;
    bit           eo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [W-1:0] seen[$];
    int           n;

    tbl[0] = '{0, 16'hFFFF, 1, 0,   0, 0, 0, 0};  // finish without valid ignored
    tbl[1] = '{1, 16'h0001, 1, 0,   0, 0, 1, 0};
    tbl[2] = '{1, 16'h0001, 1, 0, 100, 0, 1, 1};  // repeat finish: overflow, first value kept
    tbl[3] = '{0, 16'h0000, 1, 1,   0, 0, 1, 0};
    tbl[4] = '{1, 16'hFFFE, 1, 0,   0, 1, 1, 0};
    tbl[5] = '{1, 16'h0020, 0, 0,   0, 1, 1, 1};  // finish during drain dropped
    tbl[6] = '{0, 16'h0000, 0, 1,   0, 1, 1, 0};
    tbl[7] = '{1, 16'h0001, 0, 1,   0, 1, 1, 1};  // set beats clear

    rst_n = 0; i_valid = 0; i_finish = '0; i_ready = 0; i_clear_overflow = 0; i_c = '0;
    model_reset();
    #12;
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_ovf", {31'd0, o_overflow}, 32'd0);
    check("reset_data", {11'd0, o_data}, 32'd0);
    rst_n = 1;

    // Staggered anti-diagonal skew, ready always high.
    set_c_plus1();
    for (int d = 0; d < 7; d++) step(1, diag(d), 1, 0, "t1_skew");
    check("t1_latency", {31'd0, o_valid}, 32'd1);
    for (int i = 0; i < N; i++) begin
      check("t1_word", {11'd0, o_data}, 32'(i + 1));
      step(0, '0, 1, 0, "t1_drain");
    end
    check("t1_done", {31'd0, o_valid}, 32'd0);

    // Same matrix with ready toggling; every word exactly once.
    for (int d = 0; d < 7; d++) step(1, diag(d), 1, 0, "t2_skew");
    seen.delete();
    n = 0;
    while (o_valid && n < 40) begin
      if (n % 2 == 0) seen.push_back(o_data);
      step(0, '0, (n % 2 == 0), 0, "t2_drain");
      n++;
    end
    check("t2_count", 32'(seen.size()), 32'd16);
    for (int i = 0; i < seen.size() && i < N; i++) check("t2_word", {11'd0, seen[i]}, 32'(i + 1));

    // Table: finish-without-valid, repeat overflow, drop during drain, clear priority.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) i_c[k*W +: W] = W'(k * 3 + 7 + tbl[r].cofs);
      step(tbl[r].v, tbl[r].fin, tbl[r].rdy, tbl[r].clr, "tbl");
      check("tbl_valid", {31'd0, o_valid}, {31'd0, tbl[r].ev});
      check("tbl_busy", {31'd0, o_busy}, {31'd0, tbl[r].eb});
      check("tbl_ovf", {31'd0, o_overflow}, {31'd0, tbl[r].eo});
    end
    check("tbl_first_kept", {11'd0, o_data}, 32'd7);
    n = 0;
    while (o_valid && n < 20) begin step(0, '0, 1, 1, "tbl_drain"); n++; end
    check("tbl_drained", {31'd0, o_valid}, 32'd0);

    // All PEs in one cycle, values with the top bit set.
    for (int k = 0; k < N; k++) i_c[k*W +: W] = 21'h1FFFFF - W'(k);
    step(1, 16'hFFFF, 1, 0, "t4_cap");
    check("t4_direct", {31'd0, o_valid}, 32'd1);
    for (int i = 0; i < N; i++) begin
      check("t4_word", {11'd0, o_data}, 32'(21'h1FFFFF - W'(i)));
      step(0, '0, 1, 0, "t4_drain");
    end

    // Reset after a partial collect, then after a partial drain.
    set_c_plus1();
    step(1, 16'h00FF, 1, 0, "t5_part");
    mid_reset("t5a");
    step(1, 16'hFFFF, 1, 0, "t5_cap");
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, "t5_drain3");
    mid_reset("t5b");
    step(1, 16'hFFFF, 1, 0, "t5_cap2");
    for (int i = 0; i < N; i++) begin
      check("t5_word", {11'd0, o_data}, 32'(i + 1));
      step(0, '0, 1, 0, "t5_drain");
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0] fin;
      for (int k = 0; k < N; k++) begin
        i_c[k*W +: W] = W'($urandom);
        fin[k] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 299) == 0) mid_reset("rnd");
      else step($urandom_range(0, 3) != 0, fin, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
